ex_stage_pipelined: RTL and testbench

//  Parametrised execute stage. Successor of the single-cycle EX stage.
//  - Computes the ALU result, Val2 and branch target as before.
//  - Adds valid/ready handshakes and a registered EX/MEM output slot.
//  - Owns the NZCV status register and adds an iterative MUL/MLA unit.
//  - Sits between the ID/EX register and the MEM stage; flushed by the hazard/branch unit.

---
 rtl/ex_pkg.sv | 43 ++++
 rtl/ex_stage_pipelined_val2_gen.sv | 47 ++++
 rtl/ex_stage_pipelined.sv | 199 +++++++++++++++++++
 tb/tb_ex_stage_pipelined.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types for the pipelined execute stage
package ex_pkg;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        MOV = 4'd1,
        ADD = 4'd2,
        ADC = 4'd3,
        SUB = 4'd4,
        SBC = 4'd5,
        AND = 4'd6,
        ORR = 4'd7,
        EOR = 4'd8,
        MVN = 4'd9,
        MUL = 4'd10,
        MLA = 4'd11
    } exe_cmd_e;

    typedef enum logic [1:0] {
        LSL = 2'd0,
        LSR = 2'd1,
        ASR = 2'd2,
        ROR = 2'd3
    } shift_type_e;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    function automatic logic is_mul_cmd(input exe_cmd_e cmd);
        return (cmd == MUL) || (cmd == MLA);
    endfunction

endpackage

// File: rtl/ex_stage_pipelined_val2_gen.sv
// rtl/ex_stage_pipelined_val2_gen.sv - combinational second-operand generator
module val2_gen
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] val_rm,
    input  logic              imm,
    input  logic              mem_op,
    input  logic [11:0]       shift_operand,
    output logic [DATA_W-1:0] val2
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   imm_ext;
    logic [DATA_W-1:0]   shifted;
    logic [2*DATA_W-1:0] imm_dbl;
    logic [2*DATA_W-1:0] rm_dbl;
    logic [SH_W-1:0]     rot;
    logic [SH_W-1:0]     sh_amt;
    shift_type_e         sh_type;

    always_comb begin
        imm_ext = DATA_W'(shift_operand[7:0]);
        // truncation to SH_W bits is exactly the mod-DATA_W wrap we want
        rot     = SH_W'({shift_operand[11:8], 1'b0});
        sh_amt  = SH_W'(shift_operand[11:7]);
        sh_type = shift_type_e'(shift_operand[6:5]);
        imm_dbl = {imm_ext, imm_ext} >> rot;
        rm_dbl  = {val_rm, val_rm} >> sh_amt;
        shifted = rm_dbl[DATA_W-1:0];
        case (sh_type)
            LSL: shifted = val_rm << sh_amt;
            LSR: shifted = val_rm >> sh_amt;
            ASR: shifted = $signed(val_rm) >>> sh_amt;
            ROR: shifted = rm_dbl[DATA_W-1:0];
        endcase
        if (imm) begin
            val2 = imm_dbl[DATA_W-1:0];
        end else if (mem_op) begin
            val2 = DATA_W'(shift_operand);
        end else begin
            val2 = shifted;
        end
    end

endmodule

// File: rtl/ex_stage_pipelined.sv
// rtl/ex_stage_pipelined.sv - execute stage with handshakes, NZCV and iterative MUL/MLA
module ex_stage_pipelined
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 24,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        exe_cmd,
    input  logic              s_bit,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] dest,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] val_ra,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [IMM_W-1:0]  signed_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] br_addr,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_AW-1:0] out_dest,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [3:0]        status
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    exe_cmd_e          cmd;
    state_e            state, state_nxt;
    status_t           stat_q, alu_flags;
    logic [DATA_W-1:0] val2, alu_res, add_b, br_calc;
    logic [DATA_W:0]   sum;
    logic              carry_in, arith, is_mul, slot_free, accept, mul_done, mul_load;

    logic [DATA_W-1:0] mul_acc, mul_mcand, mul_mplier;
    logic [CNT_W-1:0]  mul_cnt;
    logic              p_s, p_wb, p_mr, p_mw;
    logic [REG_AW-1:0] p_dest;
    logic [DATA_W-1:0] p_br, p_store;

    assign cmd       = exe_cmd_e'(exe_cmd);
    assign is_mul    = is_mul_cmd(cmd);
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == ST_IDLE) && slot_free;
    assign accept    = in_valid && in_ready && !flush;
    assign mul_done  = (state == ST_MUL) && (mul_cnt == CNT_W'(DATA_W));
    assign mul_load  = !flush && slot_free && (mul_done || state == ST_WAIT);
    assign br_calc   = pc + (DATA_W'($signed(signed_imm)) << 2);
    assign status    = stat_q;

    val2_gen #(.DATA_W(DATA_W)) u_val2 (
        .val_rm        (val_rm),
        .imm           (imm),
        .mem_op        (mem_r_en | mem_w_en),
        .shift_operand (shift_operand),
        .val2          (val2)
    );

    // Subtraction is rn + ~val2 + carry so C naturally means "no borrow".
    always_comb begin
        add_b    = val2;
        carry_in = 1'b0;
        arith    = 1'b0;
        case (cmd)
            ADD: arith = 1'b1;
            ADC: begin arith = 1'b1; carry_in = stat_q.c; end
            SUB: begin arith = 1'b1; add_b = ~val2; carry_in = 1'b1; end
            SBC: begin arith = 1'b1; add_b = ~val2; carry_in = stat_q.c; end
            default: ;
        endcase
        sum = {1'b0, val_rn} + {1'b0, add_b} + (DATA_W+1)'(carry_in);
        case (cmd)
            MOV:                alu_res = val2;
            MVN:                alu_res = ~val2;
            ADD, ADC, SUB, SBC: alu_res = sum[DATA_W-1:0];
            AND:                alu_res = val_rn & val2;
            ORR:                alu_res = val_rn | val2;
            EOR:                alu_res = val_rn ^ val2;
            default:            alu_res = '0;
        endcase
        alu_flags   = stat_q;
        alu_flags.n = alu_res[DATA_W-1];
        alu_flags.z = (alu_res == '0);
        if (arith) begin
            alu_flags.c = sum[DATA_W];
            alu_flags.v = (val_rn[DATA_W-1] == add_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != val_rn[DATA_W-1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
                ST_MUL:  if (mul_done) state_nxt = slot_free ? ST_IDLE : ST_WAIT;
                ST_WAIT: if (slot_free) state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            alu_result   <= '0;
            br_addr      <= '0;
            store_data   <= '0;
            out_dest     <= '0;
            out_wb_en    <= 1'b0;
            out_mem_r_en <= 1'b0;
            out_mem_w_en <= 1'b0;
            stat_q       <= '0;
            mul_acc      <= '0;
            mul_mcand    <= '0;
            mul_mplier   <= '0;
            mul_cnt      <= '0;
            p_s          <= 1'b0;
            p_wb         <= 1'b0;
            p_mr         <= 1'b0;
            p_mw         <= 1'b0;
            p_dest       <= '0;
            p_br         <= '0;
            p_store      <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept && !is_mul) begin
                out_valid    <= 1'b1;
                alu_result   <= alu_res;
                br_addr      <= br_calc;
                store_data   <= val_rm;
                out_dest     <= dest;
                out_wb_en    <= wb_en;
                out_mem_r_en <= mem_r_en;
                out_mem_w_en <= mem_w_en;
                if (s_bit) stat_q <= alu_flags;
            end else if (mul_load) begin
                out_valid    <= 1'b1;
                alu_result   <= mul_acc;
                br_addr      <= p_br;
                store_data   <= p_store;
                out_dest     <= p_dest;
                out_wb_en    <= p_wb;
                out_mem_r_en <= p_mr;
                out_mem_w_en <= p_mw;
                if (p_s) begin
                    stat_q.n <= mul_acc[DATA_W-1];
                    stat_q.z <= (mul_acc == '0);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // Radix-2 shift-add; the accumulator is pre-seeded with Ra for MLA.
            if (accept && is_mul) begin
                mul_acc    <= (cmd == MLA) ? val_ra : '0;
                mul_mcand  <= val_rn;
                mul_mplier <= val_rm;
                mul_cnt    <= '0;
                p_s        <= s_bit;
                p_wb       <= wb_en;
                p_mr       <= mem_r_en;
                p_mw       <= mem_w_en;
                p_dest     <= dest;
                p_br       <= br_calc;
                p_store    <= val_rm;
            end else if (state == ST_MUL && !mul_done) begin
                if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
                mul_mcand  <= mul_mcand << 1;
                mul_mplier <= mul_mplier >> 1;
                mul_cnt    <= mul_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_pipelined.sv
// tb/tb_ex_stage_pipelined.sv - scoreboard bench for ex_stage_pipelined
module tb_ex_stage_pipelined;
    import ex_pkg::*;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk, reset, flush, in_valid, in_ready, s_bit, mem_r_en, mem_w_en, wb_en, imm;
    logic        out_valid, out_ready, out_wb_en, out_mem_r_en, out_mem_w_en;
    logic [3:0]  exe_cmd, status, dest, out_dest;
    logic [31:0] pc, val_rn, val_rm, val_ra, alu_result, br_addr, store_data;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm;

    typedef struct packed {
        logic [3:0]  cmd;
        logic        s, mr, mw, wb, imm;
        logic [3:0]  dest;
        logic [31:0] pc, rn, rm, ra;
        logic [11:0] so;
        logic [23:0] simm;
    } op_t;

    typedef struct packed {
        logic [31:0] res, br, store;
        logic [3:0]  dest, status;
        logic        wb, mr, mw;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_status;
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic       rand_rdy, rnd_rdy, rdy_cmd;

    assign out_ready = rand_rdy ? rnd_rdy : rdy_cmd;

    ex_stage_pipelined #(.DATA_W(32), .IMM_W(24), .REG_AW(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .exe_cmd(exe_cmd), .s_bit(s_bit), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .wb_en(wb_en), .dest(dest), .pc(pc), .val_rn(val_rn), .val_rm(val_rm),
        .val_ra(val_ra), .imm(imm), .shift_operand(shift_operand), .signed_imm(signed_imm),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .br_addr(br_addr), .store_data(store_data), .out_dest(out_dest),
        .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
        .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int r);
        logic [31:0] y;
        y = x;
        for (int i = 0; i < r % 32; i++) y = {y[0], y[31:1]};
        return y;
    endfunction

    function automatic logic [31:0] m_val2(input op_t o);
        int r;
        if (o.imm) return rotr({24'b0, o.so[7:0]}, 2 * int'(o.so[11:8]));
        if (o.mr || o.mw) return {20'b0, o.so};
        r = int'(o.so[11:7]);
        case (o.so[6:5])
            2'd0:    return o.rm << r;
            2'd1:    return o.rm >> r;
            2'd2:    return $signed(o.rm) >>> r;
            default: return rotr(o.rm, r);
        endcase
    endfunction

    // Reference: plain 64-bit arithmetic, range checks for V, unsigned compare for borrow.
    function automatic exp_t model(input op_t o);
        exp_t            e;
        logic [31:0]     v2, r;
        longint unsigned ua, ub, nb;
        longint          sa, sb, sr;
        logic            c, v, arith;
        v2 = m_val2(o);
        ua = 64'(o.rn);
        ub = 64'(v2);
        sa = longint'($signed(o.rn));
        sb = longint'($signed(v2));
        c = m_status[3];
        v = m_status[2];
        nb = c ? 64'd0 : 64'd1;
        arith = 1'b1;
        sr = 0;
        r = 32'h0;
        case (o.cmd)
            4'd2:  begin r = 32'(ua + ub);      c = (ua + ub) > 64'hFFFF_FFFF;      sr = sa + sb; end
            4'd3:  begin r = 32'(ua + ub + 64'(m_status[3])); c = (ua + ub + 64'(m_status[3])) > 64'hFFFF_FFFF;
                         sr = sa + sb + longint'(m_status[3]); end
            4'd4:  begin r = 32'(ua - ub);      c = ua >= ub;        sr = sa - sb; end
            4'd5:  begin r = 32'(ua - ub - nb); c = ua >= ub + nb;   sr = sa - sb - longint'(nb); end
            default: begin
                arith = 1'b0;
                case (o.cmd)
                    4'd1:  r = v2;
                    4'd6:  r = o.rn & v2;
                    4'd7:  r = o.rn | v2;
                    4'd8:  r = o.rn ^ v2;
                    4'd9:  r = ~v2;
                    4'd10: r = 32'(64'(o.rn) * 64'(o.rm));
                    4'd11: r = 32'(64'(o.rn) * 64'(o.rm) + 64'(o.ra));
                    default: r = 32'h0;
                endcase
            end
        endcase
        if (arith) v = (sr > SMAX) || (sr < SMIN);
        if (o.s) m_status = arith ? {c, v, r[31], r == 0} : {m_status[3:2], r[31], r == 0};
        e.res    = r;
        e.br     = o.pc + 32'(int'($signed(o.simm)) * 4);
        e.store  = o.rm;
        e.dest   = o.dest;
        e.wb     = o.wb;
        e.mr     = o.mr;
        e.mw     = o.mw;
        e.status = m_status;
        return e;
    endfunction

    function automatic op_t mk(input logic [3:0] c, input logic s, input logic [31:0] rn,
                               input logic [31:0] rm, input logic im, input logic [11:0] so);
        op_t o;
        o      = '0;
        o.cmd  = c;
        o.s    = s;
        o.rn   = rn;
        o.rm   = rm;
        o.imm  = im;
        o.so   = so;
        o.wb   = 1'b1;
        o.dest = 4'd3;
        o.pc   = 32'h200;
        return o;
    endfunction

    task automatic apply(input op_t o);
        exe_cmd = o.cmd; s_bit = o.s; mem_r_en = o.mr; mem_w_en = o.mw; wb_en = o.wb;
        dest = o.dest; pc = o.pc; val_rn = o.rn; val_rm = o.rm; val_ra = o.ra;
        imm = o.imm; shift_operand = o.so; signed_imm = o.simm;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive(input op_t o, output int acc_cyc);
        int n;
        apply(o);
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(in_ready && !flush) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send(input op_t o);
        int ac;
        exp_q.push_back(model(o));
        drive(o, ac);
    endtask

    task automatic send_chk(input op_t o, input logic [31:0] exp_res, input string name);
        send(o);
        @(negedge clk);
        chk(name, alu_result, exp_res);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_result", alu_result, e.res);
                chk("mon_br_addr", br_addr, e.br);
                chk("mon_store", store_data, e.store);
                chk("mon_ctrl", {out_dest, out_wb_en, out_mem_r_en, out_mem_w_en},
                    {e.dest, e.wb, e.mr, e.mw});
                chk("mon_status", status, e.status);
            end
        end
    end

    initial begin
        op_t o;
        int  ac, bad;
        logic [3:0] saved;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; rand_rdy = 1'b0; rdy_cmd = 1'b1;
        m_status = 4'b0;
        apply('0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_status", status, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", alu_result, 0);
        @(posedge clk);
        #1;

        send_chk(mk(ADD, 1, 32'h7FFF_FFFF, 0, 1, 12'h001), 32'h8000_0000, "t1_add_result");
        chk("t1_status", status, 4'b0110);

        send(mk(SUB, 1, 32'd5, 32'd5, 0, 12'h000));
        chk("t2_sub_status", status, 4'b1001);
        send_chk(mk(ADC, 1, 32'd0, 32'd0, 0, 12'h000), 32'd1, "t2_adc_result");
        chk("t2_adc_status", status, 4'b0000);

        o = mk(MLA, 0, 32'd3, 32'hFFFF_FFFF, 0, 12'h000);
        o.ra = 32'd4;
        exp_q.push_back(model(o));
        drive(o, ac);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) bad++;
        end
        chk("t3_latency", 32'(cyc - ac), 32'd33);
        chk("t3_busy_in_ready", 32'(bad), 32'd0);
        chk("t3_mla_result", alu_result, 32'd1);
        @(posedge clk);
        #1;

        rdy_cmd = 1'b0;
        send(mk(ORR, 0, 32'hF0, 32'h0F, 0, 12'h000));
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || alu_result != 32'hFF || in_ready) bad++;
        end
        chk("t4_slot_hold", 32'(bad), 32'd0);
        @(posedge clk);
        #1 rdy_cmd = 1'b1;
        @(posedge clk);
        #1;
        send(mk(MUL, 1, 32'd12345, 32'd1000, 0, 12'h000));
        rdy_cmd = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("t4_mul_loaded", out_valid, 1);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (!out_valid || alu_result != 32'd12345000 || in_ready) bad++;
        end
        chk("t4_mul_hold", 32'(bad), 32'd0);
        @(posedge clk);
        #1 rdy_cmd = 1'b1;
        @(posedge clk);
        #1;

        saved = m_status;
        drive(mk(MUL, 1, 32'd0, 32'd9, 0, 12'h000), ac);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("t5_flush_out_valid", out_valid, 0);
        chk("t5_flush_status", status, saved);
        chk("t5_flush_in_ready", in_ready, 1);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("t5_no_late_output", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        apply(mk(MOV, 1, 0, 32'h0, 0, 12'h000));
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("t5_flush_blocks_accept", out_valid, 0);
        chk("t5_flush_blocks_status", status, saved);
        @(posedge clk);
        #1;

        send_chk(mk(MOV, 0, 0, 32'h8000_0001, 0, 12'h0C0), 32'hC000_0000, "t6_asr");
        send_chk(mk(MOV, 0, 0, 0, 1, 12'h4FF), 32'hFF00_0000, "t6_imm_rot");
        o = mk(MOV, 0, 0, 0, 1, 12'h000);
        o.pc = 32'h100;
        o.simm = 24'hFFFFFE;
        send(o);
        @(negedge clk);
        chk("t6_br_addr", br_addr, 32'hF8);
        @(posedge clk);
        #1;
        o = mk(ADD, 0, 32'h1000, 32'h5555, 0, 12'hABC);
        o.mw = 1'b1;
        send_chk(o, 32'h1ABC, "t6_mem_val2");

        drive(mk(MLA, 1, 32'd7, 32'd7, 0, 12'h000), ac);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_status", status, 0);
        chk("async_rst_in_ready", in_ready, 1);
        m_status = 4'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        rand_rdy = 1'b1;
        for (int k = 0; k < 250; k++) begin
            o      = '0;
            o.cmd  = 4'($urandom_range(1, 11));
            o.s    = 1'($urandom);
            o.rn   = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom;
            o.rm   = ($urandom_range(0, 4) == 0) ? o.rn : $urandom;
            o.ra   = $urandom;
            o.imm  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       o.mr = 1'b1;
                1:       o.mw = 1'b1;
                default: ;
            endcase
            o.wb   = 1'($urandom);
            o.dest = 4'($urandom);
            o.pc   = $urandom;
            o.so   = 12'($urandom);
            o.simm = 24'($urandom);
            send(o);
        end
        rand_rdy = 1'b0;
        rdy_cmd = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("final_status", status, m_status);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
